// File: rtl/bbox_sequencer.sv
// bbox_sequencer: frame-level controller for the boundingBox scanner.
// Ports: frame_valid in; bb_start/bb_rst_n/scan_active to scanner/mux;
//   bb_done + bb_x/y_min/max raw results in; res_* record out with
//   res_valid/res_ready handshake; drop_cnt saturating dropped-frame count.
module bbox_sequencer #(
  parameter int WIDTH   = 100,
  parameter int HEIGHT  = 100,
  parameter int TIMEOUT = 40000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  output logic        bb_start,
  input  logic        bb_done,
  output logic        bb_rst_n,
  input  logic [10:0] bb_x_min,
  input  logic [10:0] bb_x_max,
  input  logic [10:0] bb_y_min,
  input  logic [10:0] bb_y_max,
  output logic        scan_active,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_x_min,
  output logic [10:0] res_x_max,
  output logic [10:0] res_row_min,
  output logic [10:0] res_row_max,
  output logic [10:0] res_w,
  output logic [10:0] res_h,
  output logic [10:0] res_cx,
  output logic [10:0] res_cy,
  output logic        res_empty,
  output logic        res_err,
  output logic [7:0]  drop_cnt
);

  // Watchdog is wide enough for both TIMEOUT and a full legal scan.
  localparam int SCAN_MIN = WIDTH * HEIGHT * 3 + 4;
  localparam int WD_CAP   = (TIMEOUT > SCAN_MIN) ? TIMEOUT : SCAN_MIN;
  localparam int WDW      = $clog2(WD_CAP + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, START, SCAN, CALC, OUT, RECOVER
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [WDW-1:0] wd;
  logic           rec_cnt;
  logic           pending;
  logic [10:0]    lx0;
  logic [10:0]    lx1;
  logic [10:0]    ly0;
  logic [10:0]    ly1;
  logic [10:0]    rmin;
  logic [10:0]    rmax;
  logic           empty_c;
  logic           scan_done;

  // wd==0 marks the first SCAN cycle, where done may still be stale.
  assign scan_done = (state == SCAN) && bb_done && (wd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_valid || pending) state_nx = START;
      START:   state_nx = SCAN;
      SCAN: begin
        if (scan_done)          state_nx = CALC;
        else if (wd == WD_LAST) state_nx = RECOVER;
      end
      CALC:    state_nx = OUT;
      OUT:     if (res_ready) state_nx = IDLE;
      RECOVER: if (rec_cnt) state_nx = OUT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bb_start    = (state == START);
    scan_active = (state == START) || (state == SCAN);
    res_valid   = (state == OUT);
    bb_rst_n    = (state != RECOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      rec_cnt <= 1'b0;
    end else begin
      if (state == START)     wd <= '0;
      else if (state == SCAN) wd <= wd + WDW'(1);
      rec_cnt <= (state == RECOVER);
    end
  end

  // One frame may wait; further arrivals while busy are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      drop_cnt <= '0;
    end else if (state == IDLE) begin
      pending <= 1'b0;
    end else if (frame_valid) begin
      if (!pending)                pending  <= 1'b1;
      else if (drop_cnt != 8'hff)  drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx0 <= '0;
      lx1 <= '0;
      ly0 <= '0;
      ly1 <= '0;
    end else if (scan_done) begin
      lx0 <= bb_x_min;
      lx1 <= bb_x_max;
      ly0 <= bb_y_min;
      ly1 <= bb_y_max;
    end
  end

  // Scanner y counts byte rows (3 per pixel row).
  always_comb begin
    rmin    = ly0 / 11'd3;
    rmax    = ly1 / 11'd3;
    empty_c = (lx1 < lx0) || (ly1 < ly0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_x_min   <= '0;
      res_x_max   <= '0;
      res_row_min <= '0;
      res_row_max <= '0;
      res_w       <= '0;
      res_h       <= '0;
      res_cx      <= '0;
      res_cy      <= '0;
      res_empty   <= 1'b0;
      res_err     <= 1'b0;
    end else if (state == CALC) begin
      res_err   <= 1'b0;
      res_empty <= empty_c;
      if (empty_c) begin
        res_x_min   <= '0;
        res_x_max   <= '0;
        res_row_min <= '0;
        res_row_max <= '0;
        res_w       <= '0;
        res_h       <= '0;
        res_cx      <= '0;
        res_cy      <= '0;
      end else begin
        res_x_min   <= lx0;
        res_x_max   <= lx1;
        res_row_min <= rmin;
        res_row_max <= rmax;
        res_w  <= 11'({1'b0, lx1} - {1'b0, lx0} + 12'd1);
        res_h  <= 11'({1'b0, rmax} - {1'b0, rmin} + 12'd1);
        res_cx <= 11'(({1'b0, lx0} + {1'b0, lx1}) >> 1);
        res_cy <= 11'(({1'b0, rmin} + {1'b0, rmax}) >> 1);
      end
    end else if ((state == RECOVER) && rec_cnt) begin
      res_x_min   <= '0;
      res_x_max   <= '0;
      res_row_min <= '0;
      res_row_max <= '0;
      res_w       <= '0;
      res_h       <= '0;
      res_cx      <= '0;
      res_cy      <= '0;
      res_empty   <= 1'b0;
      res_err     <= 1'b1;
    end
  end

endmodule
